// File: rtl/buzzer_pkg.sv
// Shared note/octave codes, base pitch table and FSM state type for the buzzer path.
// The tone_generator duty cycle is selected by the TONE_QUIET_EN macro (see tone_generator.sv).
package buzzer_pkg;

    localparam logic [3:0] NOTE_REST = 4'd0;
    localparam logic [3:0] NOTE_DO   = 4'd1;
    localparam logic [3:0] NOTE_RE   = 4'd2;
    localparam logic [3:0] NOTE_MI   = 4'd3;
    localparam logic [3:0] NOTE_FA   = 4'd4;
    localparam logic [3:0] NOTE_SOL  = 4'd5;
    localparam logic [3:0] NOTE_LA   = 4'd6;
    localparam logic [3:0] NOTE_TI   = 4'd7;
    localparam logic [3:0] NOTE_END  = 4'd15;

    localparam logic [1:0] OCT_MID = 2'b00;
    localparam logic [1:0] OCT_LO  = 2'b01;
    localparam logic [1:0] OCT_HI  = 2'b10;

    // Middle-octave frequencies in Hz for NOTE_DO..NOTE_TI.
    localparam int unsigned BASE_HZ [7] = '{262, 294, 330, 349, 392, 440, 494};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } tone_state_e;

    function automatic logic note_is_tone(input logic [3:0] note);
        return (note >= NOTE_DO) && (note <= NOTE_TI);
    endfunction

endpackage

// File: rtl/note_period_lut.sv
// Combinational (note, octave, enable) -> period in clock cycles; 0 means silence.
// Base periods are CLK_HZ / f, evaluated at elaboration.
module note_period_lut
    import buzzer_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100000000,
    parameter int          PW     = 21
) (
    input  logic [3:0]    note,
    input  logic [1:0]    octave,
    input  logic          enable,
    output logic [PW-1:0] period
);

    // The low-octave period of the lowest note is the largest value the counter must hold.
    if ((64'(2) * 64'(CLK_HZ) / 64'(262)) >= (64'(1) << PW)) begin : g_pw_check
        $error("note_period_lut: PW too narrow for CLK_HZ");
    end

    logic [PW-1:0] base_tbl [7];

    for (genvar gi = 0; gi < 7; gi++) begin : g_base
        localparam logic [PW-1:0] BASE_PERIOD = PW'(CLK_HZ / BASE_HZ[gi]);
        assign base_tbl[gi] = BASE_PERIOD;
    end

    logic [PW-1:0] base;
    logic [2:0]    note_idx;

    always_comb begin
        base     = '0;
        period   = '0;
        note_idx = 3'(note - NOTE_DO);
        if (enable && note_is_tone(note)) begin
            base = base_tbl[note_idx];
            case (octave)
                OCT_LO:  period = base << 1;
                OCT_HI:  period = base >> 1;
                default: period = base;
            endcase
        end
    end

endmodule

// File: rtl/tone_generator.sv
// Square-wave buzzer driver: pitch changes are applied only at period boundaries.
// Define TONE_QUIET_EN for a 25% duty cycle (default 50%).
module tone_generator
    import buzzer_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100000000,
    parameter int          PW     = 21
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] note_in,
    input  logic [1:0] octave_in,
    output logic       speaker,
    output logic       tone_active,
    output logic [3:0] cur_note
);

`ifdef TONE_QUIET_EN
    localparam int DUTY_SHIFT = 2;
`else
    localparam int DUTY_SHIFT = 1;
`endif

    logic [3:0]    note_reg;
    logic [1:0]    octave_reg;
    logic          enable_reg;
    logic [PW-1:0] lookup_period;

    tone_state_e   state_reg, state_next;
    logic [PW-1:0] counter_reg, counter_next;
    logic [PW-1:0] period_reg, period_next;
    logic [3:0]    loaded_note_reg, loaded_note_next;

    note_period_lut #(.CLK_HZ(CLK_HZ), .PW(PW)) u_lut (
        .note   (note_reg),
        .octave (octave_reg),
        .enable (enable_reg),
        .period (lookup_period)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            note_reg        <= NOTE_REST;
            octave_reg      <= OCT_MID;
            enable_reg      <= 1'b0;
            state_reg       <= ST_IDLE;
            counter_reg     <= '0;
            period_reg      <= '0;
            loaded_note_reg <= NOTE_REST;
        end else begin
            note_reg        <= note_in;
            octave_reg      <= octave_in;
            enable_reg      <= enable;
            state_reg       <= state_next;
            counter_reg     <= counter_next;
            period_reg      <= period_next;
            loaded_note_reg <= loaded_note_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        counter_next     = counter_reg;
        period_next      = period_reg;
        loaded_note_next = loaded_note_reg;
        case (state_reg)
            ST_IDLE: begin
                counter_next = '0;
                if (lookup_period != '0) begin
                    period_next      = lookup_period;
                    loaded_note_next = note_reg;
                    state_next       = ST_PLAY;
                end
            end
            default: begin
                if (counter_reg == period_reg - PW'(1)) begin
                    // Wrap cycle: the only point where a new pitch or silence is accepted.
                    counter_next = '0;
                    if (lookup_period == '0) begin
                        period_next      = '0;
                        loaded_note_next = NOTE_REST;
                        state_next       = ST_IDLE;
                    end else begin
                        period_next      = lookup_period;
                        loaded_note_next = note_reg;
                    end
                end else begin
                    counter_next = counter_reg + PW'(1);
                end
            end
        endcase
    end

    always_comb begin
        tone_active = (state_reg == ST_PLAY);
        speaker     = tone_active && (counter_reg < (period_reg >> DUTY_SHIFT));
        cur_note    = tone_active ? loaded_note_reg : NOTE_REST;
    end

endmodule

// File: tb/tb_tone_generator.sv
// Scoreboard bench for tone_generator at CLK_HZ=1 MHz: every completed waveform
// period (note, high cycles, length) is compared against a queue of expected periods.
module tb_tone_generator;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b1;
    logic [3:0] note_in = 4'd0;
    logic [1:0] octave_in = 2'b00;
    logic       speaker;
    logic       tone_active;
    logic [3:0] cur_note;

    int checks = 0;
    int errors = 0;
    int rec_count = 0;

    typedef struct {
        int note;
        int high;
        int len;
    } rec_t;

    rec_t exp_q[$];

    always #5 clk = ~clk;

    tone_generator #(.CLK_HZ(1000000), .PW(21)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .note_in     (note_in),
        .octave_in   (octave_in),
        .speaker     (speaker),
        .tone_active (tone_active),
        .cur_note    (cur_note)
    );

    function automatic int high_of(input int len);
`ifdef TONE_QUIET_EN
        return len >> 2;
`else
        return len >> 1;
`endif
    endfunction

    task automatic push_exp(input int note, input int len);
        rec_t r;
        r.note = note;
        r.len  = len;
        r.high = high_of(len);
        exp_q.push_back(r);
        $display("expect period: note=%0d len=%0d high=%0d", note, len, r.high);
    endtask

    task automatic check_val(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, " speaker"}, int'(speaker), 0);
        check_val({tag, " tone_active"}, int'(tone_active), 0);
        check_val({tag, " cur_note"}, int'(cur_note), 0);
    endtask

    task automatic wait_rec(input int n);
        int k = 0;
        while (rec_count < n && k < 20000) begin
            @(negedge clk);
            k++;
        end
        if (rec_count < n) begin
            checks++;
            errors++;
            $display("FAIL wait_period_%0d: got %0d periods, expected %0d", n, rec_count, n);
        end
    endtask

    task automatic wait_active(input string tag);
        int k = 0;
        while (!tone_active && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!tone_active) begin
            checks++;
            errors++;
            $display("FAIL %s start: tone_active got 0, expected 1", tag);
        end
    endtask

    // Segments start at a speaker rise while playing; they end at the next rise or when play stops.
    task automatic monitor();
        bit   prev_spk = 1'b0;
        bit   in_seg = 1'b0;
        bit   rise;
        int   hi = 0;
        int   len = 0;
        int   nt = 0;
        rec_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                in_seg   = 1'b0;
                prev_spk = 1'b0;
            end else begin
                rise = tone_active && speaker && !prev_spk;
                if (in_seg && (!tone_active || rise)) begin
                    in_seg = 1'b0;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL period_%0d: got note=%0d len=%0d high=%0d, expected none",
                                 rec_count + 1, nt, len, hi);
                    end else begin
                        e = exp_q.pop_front();
                        if (nt != e.note || hi != e.high || len != e.len) begin
                            errors++;
                            $display("FAIL period_%0d: got note=%0d len=%0d high=%0d, expected note=%0d len=%0d high=%0d",
                                     rec_count + 1, nt, len, hi, e.note, e.len, e.high);
                        end else begin
                            $display("ok   period_%0d note=%0d len=%0d high=%0d",
                                     rec_count + 1, nt, len, hi);
                        end
                    end
                    rec_count++;
                end
                if (rise) begin
                    in_seg = 1'b1;
                    hi     = 0;
                    len    = 0;
                    nt     = int'(cur_note);
                end
                if (in_seg) begin
                    len++;
                    if (speaker) hi++;
                end
                prev_spk = speaker;
            end
        end
    endtask

    initial begin
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1 check_idle("reset");
        @(negedge clk) reset = 1'b1;
        repeat (4) @(posedge clk);
        #1 check_idle("idle_after_reset");

        // Note 6 middle: 1e6/440 = 2272; speaker rises two edges after the input change.
        @(posedge clk);
        #1 note_in = 4'd6;
        octave_in = 2'b00;
        push_exp(6, 2272);
        push_exp(6, 2272);
        @(posedge clk);
        #1 check_val("lat1 speaker", int'(speaker), 0);
        check_val("lat1 tone_active", int'(tone_active), 0);
        @(posedge clk);
        #1 check_val("lat2 speaker", int'(speaker), 1);
        check_val("lat2 tone_active", int'(tone_active), 1);
        check_val("lat2 cur_note", int'(cur_note), 6);

        // Note 1: base 1e6/262 = 3816; low octave 7632, high octave 1908.
        wait_rec(1);
        note_in = 4'd1;
        octave_in = 2'b01;
        push_exp(1, 7632);
        wait_rec(2);
        octave_in = 2'b10;
        push_exp(1, 1908);
        wait_rec(3);
        note_in = 4'd6;
        octave_in = 2'b11;
        push_exp(6, 2272);

        // Mid-period change to note 5 (1e6/392 = 2551) waits for the wrap.
        wait_rec(4);
        repeat (500) @(negedge clk);
        note_in = 4'd5;
        octave_in = 2'b00;
        push_exp(5, 2551);
        wait_rec(5);
        note_in = 4'd0;
        wait_rec(6);
        check_idle("rest");

        // Note 3 (1e6/330 = 3030) ended by the end marker.
        note_in = 4'd3;
        push_exp(3, 3030);
        wait_active("note3");
        note_in = 4'd15;
        wait_rec(7);
        check_idle("end_marker");

        note_in = 4'd9;
        repeat (20) @(negedge clk);
        check_idle("code9");

        // Note 7 (1e6/494 = 2024) ended by dropping enable.
        note_in = 4'd7;
        push_exp(7, 2024);
        wait_active("note7");
        enable = 1'b0;
        wait_rec(8);
        check_idle("enable_drop");
        repeat (20) @(negedge clk);
        check_idle("enable_low");

        // Reset mid-period, then a full period restarts with note 6 held.
        note_in = 4'd6;
        enable = 1'b1;
        wait_active("pre_reset");
        repeat (300) @(posedge clk);
        #1 reset = 1'b0;
        #1 check_idle("reset_mid");
        push_exp(6, 2272);
        push_exp(6, 2272);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        wait_rec(9);
        note_in = 4'd0;
        wait_rec(10);
        check_idle("final_rest");

        repeat (10) @(negedge clk);
        check_val("leftover expected periods", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
